// File: rtl/hs32_decode_pkg.sv
// Shared definitions for the hs32 decode stage: format codes, prefix nibbles,
// the normalised field bundle and the combinational word decoder.
package hs32_decode_pkg;

  typedef enum logic [2:0] {
    FMT_IMM16   = 3'd0,
    FMT_SHIFT   = 3'd1,
    FMT_IMM24   = 3'd2,
    FMT_REG     = 3'd3,
    FMT_JUMP    = 3'd4,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  localparam logic [3:0] PFX_IMM16 = 4'h0;
  localparam logic [3:0] PFX_SHIFT = 4'h1;
  localparam logic [3:0] PFX_IMM24 = 4'h2;
  localparam logic [3:0] PFX_REG   = 4'h3;
  localparam logic [3:0] PFX_JUMP  = 4'h4;

  localparam int BUNDLE_W = 68;

  typedef struct packed {
    fmt_e        fmt;
    logic [3:0]  aluop;
    logic [3:0]  regdst;
    logic [3:0]  regsrc;
    logic [3:0]  regopd;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [11:0] ctlsig;
  } bundle_t;

  // Fields a format does not use are left at zero so execute never sees stale bits.
  function automatic bundle_t decode_word(input logic [31:0] w);
    bundle_t b;
    b = '0;
    case (w[31:28])
      PFX_IMM16: begin
        b.fmt    = FMT_IMM16;
        b.aluop  = w[27:24];
        b.regdst = w[23:20];
        b.regsrc = w[19:16];
        b.imm    = {16'h0000, w[15:0]};
      end
      PFX_SHIFT: begin
        b.fmt    = FMT_SHIFT;
        b.aluop  = w[27:24];
        b.regdst = w[23:20];
        b.regsrc = w[19:16];
        b.regopd = w[15:12];
        b.shamt  = w[11:7];
        b.ctlsig = {5'b0, w[6:0]};
      end
      PFX_IMM24: begin
        b.fmt    = FMT_IMM24;
        b.ctlsig = {8'b0, w[27:24]};
        b.imm    = {8'h00, w[23:0]};
      end
      PFX_REG: begin
        b.fmt    = FMT_REG;
        b.aluop  = w[27:24];
        b.regdst = w[23:20];
        b.regsrc = w[19:16];
        b.regopd = w[15:12];
        b.ctlsig = w[11:0];
      end
      PFX_JUMP: begin
        b.fmt    = FMT_JUMP;
        b.ctlsig = {8'b0, w[27:24]};
        b.regdst = w[23:20];
        b.aluop  = w[19:16];
        b.imm    = {{16{w[15]}}, w[15:0]};
      end
      default: begin
        b.fmt = FMT_ILLEGAL;
        b.imm = w;
      end
    endcase
    return b;
  endfunction

endpackage

// File: rtl/hs32_decode_fifo.sv
// Generic DEPTH x W synchronous FIFO with occupancy count and clear.
// Head output reads zero while empty; no write-to-read bypass.
module hs32_decode_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 68,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    dout,
  output logic [CNTW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CNTW-1:0] r_count;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wr <= next_ptr(r_wr);
      if (pop)  r_rd <= next_ptr(r_rd);
      if (push && !pop)      r_count <= r_count + 1'b1;
      else if (pop && !push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !clr && push) r_mem[r_wr] <= din;
  end

  assign dout  = (r_count != '0) ? r_mem[r_rd] : '0;
  assign count = r_count;

endmodule

// File: rtl/hs32_decode_q.sv
// hs32 decode stage: classifies fetch words and queues normalised bundles for execute.
// Optional macro HS32_DECODE_ILLEGAL_TRAP_EN: queue illegal words as fmt=7 instead of dropping them.
module hs32_decode_q
  import hs32_decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [31:0]     instd,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [2:0]      fmt,
  output logic [3:0]      aluop,
  output logic [3:0]      regdst,
  output logic [3:0]      regsrc,
  output logic [3:0]      regopd,
  output logic [31:0]     imm,
  output logic [4:0]      shamt,
  output logic [11:0]     ctlsig,
  output logic [CNTW-1:0] count
);

  bundle_t               w_dec;
  bundle_t               w_head;
  logic [BUNDLE_W-1:0]   w_dout;
  logic [CNTW-1:0]       w_count;
  logic                  w_dequeue;
  logic                  w_accept;
  logic                  w_keep;
  logic                  w_push;
  logic                  w_pop;

  assign w_dec = decode_word(instd);

`ifdef HS32_DECODE_ILLEGAL_TRAP_EN
  assign w_keep = 1'b1;
`else
  assign w_keep = (w_dec.fmt != FMT_ILLEGAL);
`endif

  // A full queue can still accept when the head leaves in the same cycle.
  assign valid_o   = (w_count != '0);
  assign w_dequeue = valid_o && ready_i;
  assign ready_o   = (w_count != CNTW'(DEPTH)) || w_dequeue;
  assign w_accept  = valid_i && ready_o;
  assign w_push    = w_accept && w_keep && !flush;
  assign w_pop     = w_dequeue && !flush;

  hs32_decode_fifo #(
    .DEPTH (DEPTH),
    .W     (BUNDLE_W),
    .CNTW  (CNTW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_dec),
    .dout  (w_dout),
    .count (w_count)
  );

  assign w_head = bundle_t'(w_dout);
  assign fmt    = w_head.fmt;
  assign aluop  = w_head.aluop;
  assign regdst = w_head.regdst;
  assign regsrc = w_head.regsrc;
  assign regopd = w_head.regopd;
  assign imm    = w_head.imm;
  assign shamt  = w_head.shamt;
  assign ctlsig = w_head.ctlsig;
  assign count  = w_count;

endmodule

// File: tb/tb_hs32_decode_q.sv
module tb_hs32_decode_q;

   logic        clk = 1'b0;
   logic        reset, flush, valid_i, ready_i;
   logic [31:0] instd;
   logic        ready_o, valid_o;
   logic [2:0]  fmt;
   logic [3:0]  aluop, regdst, regsrc, regopd;
   logic [31:0] imm;
   logic [4:0]  shamt;
   logic [11:0] ctlsig;
   logic [1:0]  count;

   int n_pass  = 0;
   int n_total = 0;

   hs32_decode_q #(.DEPTH(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .instd   (instd),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .fmt     (fmt),
      .aluop   (aluop),
      .regdst  (regdst),
      .regsrc  (regsrc),
      .regopd  (regopd),
      .imm     (imm),
      .shamt   (shamt),
      .ctlsig  (ctlsig),
      .count   (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $error("FAIL timeout: bench did not finish");
      $finish;
   end

   initial begin
      reset = 1'b0; flush = 1'b0; ready_i = 1'b0;
      valid_i = 1'b1; instd = 32'h0123ABCD;
      step(); step();
      chk("rst_count", count, 2'd0);
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_imm", imm, 32'h0);
      chk("rst_fmt", fmt, 3'd0);

      reset = 1'b1;
      step();
      valid_i = 1'b0;
      chk("imm16_valid", valid_o, 1'b1);
      chk("imm16_count", count, 2'd1);
      chk("imm16_fmt", fmt, 3'd0);
      chk("imm16_aluop", aluop, 4'h1);
      chk("imm16_regdst", regdst, 4'h2);
      chk("imm16_regsrc", regsrc, 4'h3);
      chk("imm16_imm", imm, 32'h0000ABCD);
      ready_i = 1'b1; step(); ready_i = 1'b0;
      chk("pop_count", count, 2'd0);
      chk("pop_valid", valid_o, 1'b0);

      valid_i = 1'b1; instd = 32'h4A5F8000; step(); valid_i = 1'b0;
      chk("jump_fmt", fmt, 3'd4);
      chk("jump_ctlsig", ctlsig, 12'h00A);
      chk("jump_regdst", regdst, 4'h5);
      chk("jump_aluop", aluop, 4'hF);
      chk("jump_imm", imm, 32'hFFFF8000);
      chk("jump_regsrc", regsrc, 4'h0);
      ready_i = 1'b1; step(); ready_i = 1'b0;

      valid_i = 1'b1; instd = 32'h11234A85; step(); valid_i = 1'b0;
      chk("shift_fmt", fmt, 3'd1);
      chk("shift_aluop", aluop, 4'h1);
      chk("shift_regopd", regopd, 4'h4);
      chk("shift_shamt", shamt, 5'h15);
      chk("shift_ctlsig", ctlsig, 12'h005);
      chk("shift_imm", imm, 32'h0);
      ready_i = 1'b1; step(); ready_i = 1'b0;

      valid_i = 1'b1; instd = 32'h3ABCD123; step(); valid_i = 1'b0;
      chk("reg_fmt", fmt, 3'd3);
      chk("reg_regsrc", regsrc, 4'hC);
      chk("reg_regopd", regopd, 4'hD);
      chk("reg_ctlsig", ctlsig, 12'h123);
      chk("reg_shamt", shamt, 5'h0);
      ready_i = 1'b1; step(); ready_i = 1'b0;

      valid_i = 1'b1; instd = 32'h2C123456; step(); valid_i = 1'b0;
      chk("imm24_fmt", fmt, 3'd2);
      chk("imm24_ctlsig", ctlsig, 12'h00C);
      chk("imm24_imm", imm, 32'h00123456);
      chk("imm24_aluop", aluop, 4'h0);
      ready_i = 1'b1; step(); ready_i = 1'b0;

      valid_i = 1'b1; instd = 32'h01111111; step();
      instd = 32'h02222222; step();
      instd = 32'h03333333;
      chk("full_ready", ready_o, 1'b0);
      chk("full_count", count, 2'd2);
      step();
      chk("stall_count", count, 2'd2);
      chk("stall_head", imm, 32'h00001111);
      ready_i = 1'b1; #1;
      chk("full_pop_ready", ready_o, 1'b1);
      step();
      valid_i = 1'b0;
      chk("swap_count", count, 2'd2);
      chk("swap_head", imm, 32'h00002222);
      step();
      chk("order_head", imm, 32'h00003333);
      chk("order_count", count, 2'd1);
      step();
      chk("drain_count", count, 2'd0);
      ready_i = 1'b0;

      valid_i = 1'b1; instd = 32'h01111111; step();
      instd = 32'h02222222; step();
      instd = 32'h03333333; flush = 1'b1; ready_i = 1'b1; #1;
      chk("flush_ready", ready_o, 1'b1);
      step();
      flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
      chk("flush_count", count, 2'd0);
      chk("flush_valid", valid_o, 1'b0);
      chk("flush_imm", imm, 32'h0);
      step();
      chk("flush_dropped", count, 2'd0);

      valid_i = 1'b1; instd = 32'h70000001; #1;
      chk("illegal_ready", ready_o, 1'b1);
      step();
      valid_i = 1'b0;
`ifdef HS32_DECODE_ILLEGAL_TRAP_EN
      chk("illegal_count", count, 2'd1);
      chk("illegal_fmt", fmt, 3'd7);
      chk("illegal_imm", imm, 32'h70000001);
      chk("illegal_aluop", aluop, 4'h0);
      ready_i = 1'b1; step(); ready_i = 1'b0;
`else
      chk("illegal_count", count, 2'd0);
      chk("illegal_valid", valid_o, 1'b0);
`endif
      chk("illegal_after_ready", ready_o, 1'b1);

      ready_i = 1'b1; valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         instd = 32'h00000010 + i;
         step();
         chk("stream_imm", imm, 32'h00000010 + i);
         chk("stream_count", count, 2'd1);
      end
      valid_i = 1'b0; step();
      chk("stream_drain", count, 2'd0);

      ready_i = 1'b0; valid_i = 1'b1; instd = 32'h01111111; step(); step();
      valid_i = 1'b0;
      chk("prerst_count", count, 2'd2);
      reset = 1'b0; flush = 1'b1; step();
      reset = 1'b1; flush = 1'b0;
      chk("midrst_count", count, 2'd0);
      chk("midrst_valid", valid_o, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
